note_sequencer: RTL and testbench
=================================

// Module: note_sequencer
// PURPOSE
//  Upstream stage of the audio controller. Steps through an internal note ROM and
//  presents, per note, a tone half-period (in clk cycles) plus a gate to the tone
//  generator that drives aud. Tempo comes from an internal tick prescaler.
//  Supports start/stop control, loop mode, and a silent articulation gap between notes.
// PARAMETERS
//  TICK_DIV   1_250_000  clk cycles per tempo tick (1250000 = 0.25 s at 5 MHz)
//  GAP_TICKS  1          silent ticks inserted after each note (0 = legato, no gap)
//  NOTES      16         ROM depth, in entries
//  DIV_W      16         width of half_period
// PORTS
//  clk          in   1              system clock (single clock domain)
//  rst_n        in   1              asynchronous active-low reset
//  start        in   1              begin playback from entry 0 (level-sampled)
//  stop         in   1              abort playback
//  loop_en      in   1              restart at entry 0 at end of song instead of finishing
//  half_period  out  DIV_W          tone half-period for the tone generator; 0 during rests
//  tone_en      out  1              gate: tone generator drives aud only while 1
//  note_idx     out  $clog2(NOTES)  ROM index currently playing
//  busy         out  1              1 in any state except IDLE
//  done         out  1              one-cycle pulse at normal end of song
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE; half_period=0, tone_en=0, note_idx=0,
//    busy=0, done=0. All outputs are registered.
//  - ROM entry: {pitch[3:0], dur[3:0]}.
//    pitch 0 = rest: tone_en stays 0, half_period=0.
//    dur 0 = end-of-song marker. Reading past index NOTES-1 is also end of song.
//  - FSM states: IDLE, LOAD, PLAY, GAP, DONE.
//    IDLE: start & !stop -> LOAD with note_idx<=0. start while busy is ignored.
//    LOAD: one cycle; reads rom[note_idx] and clears the prescaler.
//      dur!=0 -> PLAY; half_period<=PITCH_LUT[pitch]; tone_en<=(pitch!=0).
//      dur==0 & loop_en & note_idx!=0 -> note_idx<=0; stay in LOAD.
//      dur==0 otherwise (including an empty song at idx 0) -> DONE.
//    PLAY: lasts exactly dur*TICK_DIV cycles.
//      Then -> GAP with tone_en<=0, half_period<=0; or -> LOAD with note_idx+1 if GAP_TICKS==0.
//    GAP: lasts exactly GAP_TICKS*TICK_DIV cycles, then -> LOAD with note_idx+1.
//      At note_idx==NOTES-1, end-of-song handling applies: wrap to 0 if loop_en, else DONE.
//    DONE: done=1 for one cycle -> IDLE. busy drops on the same edge done drops.
//  - Latency: start sampled at edge k -> LOAD after k+1 -> tone_en=1 after k+2
//    (first note is a non-rest).
//  - Tick: the prescaler counts 0..TICK_DIV-1 and pulses on TICK_DIV-1; it is cleared in LOAD.
//    The tick counter is 4 bits, so it cannot overflow for dur<=15.
//  - stop: from any state -> IDLE on the next edge. tone_en, half_period and busy clear on
//    that edge. done is NOT pulsed. note_idx holds its value.
//  - Simultaneous start & stop: stop wins.
//  - Loop mode: no done pulse is issued; busy stays 1. loop_en is sampled only in LOAD.
//  - Reset mid-note: immediate silence (tone_en=0) while rst_n is low.
// STRUCTURE
//  - Package note_pkg: pitch codes as localparams (REST, C4..B4, C5);
//    PITCH_LUT half-periods for 5 MHz (e.g. A4 = 5682); ROM entry field widths;
//    state encoding typedef; default song contents.
//  - Sub-module tempo_tick (parameter TICK_DIV; ports clk, rst_n, clr, tick):
//    prescaler plus one-cycle tick pulse. The FSM, ROM and output registers stay in
//    note_sequencer.
// TESTING  (TICK_DIV=4, GAP_TICKS=1, test ROM loaded)
//  - Reset values: hold rst_n=0 with start=1 -> all outputs 0 and state IDLE.
//    Release rst_n -> LOAD on the next edge.
//  - ROM {A4,3},{0,0}: pulse start.
//    -> tone_en=1 and half_period=5682 for 12 cycles, starting 2 cycles after start;
//    then 4 cycles of gap; then done pulses once; busy=0 one cycle later.
//  - ROM {REST,2},{C5,1},{0,0}:
//    -> tone_en=0 for the first 8 PLAY cycles and half_period=0;
//    -> then C5 plays for 4 cycles; note_idx sequence is 0,1,2.
//  - Loop, loop_en=1 with a 2-note song:
//    -> note_idx wraps 1->0 with no done pulse and busy=1 throughout.
//    Clear loop_en -> done pulses after the next pass.
//  - Stop mid-PLAY at cycle 5 of a note:
//    -> next edge: IDLE, tone_en=0, busy=0, no done pulse.
//    Start and stop asserted in the same cycle -> stays IDLE.
//  - Bounds: a full 16-entry ROM with no end marker -> ends after idx 15 and done pulses.
//    An empty song ({x,0} at idx 0) with loop_en=1 -> LOAD->DONE, no lock-up.

Source files
------------

// File: rtl/note_pkg.sv
// Shared definitions for the note sequencer: pitch codes, half-period table,
// ROM entry layout, FSM state encoding and the default song.
package note_pkg;
  localparam int PITCH_W = 4;
  localparam int DUR_W   = 4;
  localparam int ENTRY_W = PITCH_W + DUR_W;

  localparam logic [PITCH_W-1:0] REST = 4'd0;
  localparam logic [PITCH_W-1:0] C4   = 4'd1;
  localparam logic [PITCH_W-1:0] D4   = 4'd2;
  localparam logic [PITCH_W-1:0] E4   = 4'd3;
  localparam logic [PITCH_W-1:0] F4   = 4'd4;
  localparam logic [PITCH_W-1:0] G4   = 4'd5;
  localparam logic [PITCH_W-1:0] A4   = 4'd6;
  localparam logic [PITCH_W-1:0] B4   = 4'd7;
  localparam logic [PITCH_W-1:0] C5   = 4'd8;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP, S_DONE} state_t;

  typedef struct packed {
    logic [PITCH_W-1:0] pitch;
    logic [DUR_W-1:0]   dur;
  } entry_t;

  // Half-periods in 5 MHz clk cycles; codes above C5 continue up to C6.
  function automatic logic [15:0] pitch_lut(input logic [PITCH_W-1:0] p);
    case (p)
      C4:      return 16'd9556;
      D4:      return 16'd8513;
      E4:      return 16'd7584;
      F4:      return 16'd7159;
      G4:      return 16'd6378;
      A4:      return 16'd5682;
      B4:      return 16'd5062;
      C5:      return 16'd4778;
      4'd9:    return 16'd4257;
      4'd10:   return 16'd3792;
      4'd11:   return 16'd3579;
      4'd12:   return 16'd3189;
      4'd13:   return 16'd2841;
      4'd14:   return 16'd2531;
      4'd15:   return 16'd2389;
      default: return 16'd0;
    endcase
  endfunction

  // Entry i lives at bits [i*ENTRY_W +: ENTRY_W]: C4 E4 G4 C5(long), end.
  localparam logic [16*ENTRY_W-1:0] DEFAULT_SONG =
    {88'h0, 8'h00, 8'h84, 8'h52, 8'h32, 8'h12};
endpackage

// File: rtl/tempo_tick.sv
// Tempo prescaler: counts 0..TICK_DIV-1 and pulses tick on the last count.
module tempo_tick #(
  parameter int TICK_DIV = 1_250_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = !clr && (cnt == W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else                 cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/note_sequencer.sv
// Steps through the note ROM and presents half-period + gate per note to the
// tone generator; tempo from tempo_tick, with start/stop, loop and note gaps.
module note_sequencer
  import note_pkg::*;
#(
  parameter int TICK_DIV  = 1_250_000,
  parameter int GAP_TICKS = 1,
  parameter int NOTES     = 16,
  parameter int DIV_W     = 16,
  parameter logic [NOTES*ENTRY_W-1:0] SONG = (NOTES*ENTRY_W)'(DEFAULT_SONG)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  output logic [DIV_W-1:0]         half_period,
  output logic                     tone_en,
  output logic [$clog2(NOTES)-1:0] note_idx,
  output logic                     busy,
  output logic                     done
);
  localparam int IDX_W = $clog2(NOTES);

  state_t             state, n_state;
  logic [IDX_W-1:0]   n_idx;
  logic [DIV_W-1:0]   n_hp;
  logic               n_ten, n_busy, n_done;
  logic [3:0]         tcnt, n_tcnt;
  logic               eos, n_eos;   // walked past the last ROM entry
  logic               clr, tick;
  entry_t             ent;

  tempo_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .tick (tick)
  );

  assign ent = eos ? entry_t'('0) : entry_t'(SONG[note_idx*ENTRY_W +: ENTRY_W]);

  always_comb begin
    n_state = state;
    n_idx   = note_idx;
    n_eos   = eos;
    n_tcnt  = tcnt;
    n_hp    = half_period;
    n_ten   = tone_en;
    n_busy  = busy;
    n_done  = 1'b0;
    clr     = 1'b0;
    if (stop) begin
      n_state = S_IDLE;
      n_hp    = '0;
      n_ten   = 1'b0;
      n_busy  = 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          n_state = S_LOAD;
          n_idx   = '0;
          n_eos   = 1'b0;
          n_busy  = 1'b1;
        end
        S_LOAD: begin
          clr    = 1'b1;
          n_tcnt = '0;
          if (ent.dur != '0) begin
            n_state = S_PLAY;
            n_hp    = DIV_W'(pitch_lut(ent.pitch));
            n_ten   = (ent.pitch != REST);
          end else if (loop_en && note_idx != '0) begin
            n_idx = '0;
            n_eos = 1'b0;
          end else begin
            n_state = S_DONE;
            n_done  = 1'b1;
            n_hp    = '0;
            n_ten   = 1'b0;
          end
        end
        S_PLAY: if (tick) begin
          n_tcnt = tcnt + 1'b1;
          if (tcnt == ent.dur - 4'd1) begin
            n_tcnt = '0;
            if (GAP_TICKS == 0) begin
              n_state = S_LOAD;
              if (note_idx == IDX_W'(NOTES - 1)) n_eos = 1'b1;
              else                               n_idx = note_idx + 1'b1;
            end else begin
              n_state = S_GAP;
              n_hp    = '0;
              n_ten   = 1'b0;
            end
          end
        end
        S_GAP: if (tick) begin
          n_tcnt = tcnt + 1'b1;
          if (tcnt == 4'(GAP_TICKS - 1)) begin
            n_tcnt  = '0;
            n_state = S_LOAD;
            if (note_idx == IDX_W'(NOTES - 1)) n_eos = 1'b1;
            else                               n_idx = note_idx + 1'b1;
          end
        end
        S_DONE: begin
          n_state = S_IDLE;
          n_busy  = 1'b0;
        end
        default: n_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      note_idx    <= '0;
      eos         <= 1'b0;
      tcnt        <= '0;
      half_period <= '0;
      tone_en     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= n_state;
      note_idx    <= n_idx;
      eos         <= n_eos;
      tcnt        <= n_tcnt;
      half_period <= n_hp;
      tone_en     <= n_ten;
      busy        <= n_busy;
      done        <= n_done;
    end
  end
endmodule

// File: tb/tb_note_sequencer.sv
// Four sequencers with different songs share one random control stream and are
// compared every cycle against a countdown-based model of the playback rules.
module tb_note_sequencer;
  localparam int TD = 4, GAP = 1, N = 16, NI = 4;
  localparam logic [127:0] SONG0 = {112'h0, 8'h00, 8'h63};
  localparam logic [127:0] SONG1 = {104'h0, 8'h00, 8'h81, 8'h02};
  localparam logic [127:0] SONG2 = {8'h71, 8'h62, 8'h51, 8'h42, 8'h31, 8'h22, 8'h12, 8'h01,
                                    8'h81, 8'h72, 8'h61, 8'h52, 8'h41, 8'h32, 8'h21, 8'h12};
  localparam logic [127:0] SONG3 = {120'h0, 8'h50};
  localparam logic [NI-1:0][127:0] SONGS = {SONG3, SONG2, SONG1, SONG0};

  localparam int ST_OFF = 0, ST_FETCH = 1, ST_SOUND = 2, ST_SIL = 3, ST_FIN = 4;

  logic gclk = 1'b0, grst_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, loop_en = 1'b0;

  logic [15:0] hp   [NI];
  logic        ten  [NI];
  logic [3:0]  idx  [NI];
  logic        busy [NI];
  logic        done [NI];

  int vectors = 0, miscompares = 0;

  int m_ph [NI], m_rem [NI], m_pos [NI];
  int e_hp [NI];
  bit e_ten [NI], e_busy [NI], e_done [NI];

  always #5 gclk = ~gclk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    note_sequencer #(.TICK_DIV(TD), .GAP_TICKS(GAP), .NOTES(N), .DIV_W(16),
                     .SONG(SONGS[g])) u_dut (
      .clk        (gclk),
      .rst_n      (grst_n),
      .start      (start),
      .stop       (stop),
      .loop_en    (loop_en),
      .half_period(hp[g]),
      .tone_en    (ten[g]),
      .note_idx   (idx[g]),
      .busy       (busy[g]),
      .done       (done[g])
    );
  end

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lut(input int p);
    int t [9] = '{0, 9556, 8513, 7584, 7159, 6378, 5682, 5062, 4778};
    return (p < 9) ? t[p] : 0;
  endfunction

  function automatic logic [7:0] entry(input int m, input int pos);
    logic [127:0] s;
    s = SONGS[m];
    return (pos >= N) ? 8'h00 : s[pos*8 +: 8];
  endfunction

  task automatic model_reset(input int m);
    m_ph[m] = ST_OFF; m_rem[m] = 0; m_pos[m] = 0;
    e_hp[m] = 0; e_ten[m] = 0; e_busy[m] = 0; e_done[m] = 0;
  endtask

  task automatic next_note(input int m);
    m_ph[m] = ST_FETCH;
    m_pos[m]++;
  endtask

  task automatic model_step(input int m);
    logic [7:0] e;
    e_done[m] = 0;
    if (!grst_n) begin model_reset(m); return; end
    if (stop) begin
      m_ph[m] = ST_OFF; e_ten[m] = 0; e_hp[m] = 0; e_busy[m] = 0;
      return;
    end
    case (m_ph[m])
      ST_OFF: if (start) begin m_ph[m] = ST_FETCH; m_pos[m] = 0; e_busy[m] = 1; end
      ST_FETCH: begin
        e = entry(m, m_pos[m]);
        if (e[3:0] != 0) begin
          m_ph[m] = ST_SOUND; m_rem[m] = int'(e[3:0]) * TD;
          e_hp[m] = lut(int'(e[7:4])); e_ten[m] = (e[7:4] != 0);
        end else if (loop_en && m_pos[m] != 0) begin
          m_pos[m] = 0;
        end else begin
          m_ph[m] = ST_FIN; e_done[m] = 1; e_ten[m] = 0; e_hp[m] = 0;
        end
      end
      ST_SOUND: begin
        m_rem[m]--;
        if (m_rem[m] == 0) begin
          if (GAP > 0) begin
            m_ph[m] = ST_SIL; m_rem[m] = GAP * TD; e_ten[m] = 0; e_hp[m] = 0;
          end else next_note(m);
        end
      end
      ST_SIL: begin
        m_rem[m]--;
        if (m_rem[m] == 0) next_note(m);
      end
      ST_FIN: begin m_ph[m] = ST_OFF; e_busy[m] = 0; end
      default: m_ph[m] = ST_OFF;
    endcase
  endtask

  task automatic compare_all();
    for (int m = 0; m < NI; m++) begin
      check($sformatf("s%0d.half_period", m), int'(hp[m]), e_hp[m]);
      check($sformatf("s%0d.tone_en", m), int'(ten[m]), int'(e_ten[m]));
      check($sformatf("s%0d.note_idx", m), int'(idx[m]), (m_pos[m] > N-1) ? N-1 : m_pos[m]);
      check($sformatf("s%0d.busy", m), int'(busy[m]), int'(e_busy[m]));
      check($sformatf("s%0d.done", m), int'(done[m]), int'(e_done[m]));
    end
  endtask

  task automatic cycle(input int n = 1);
    repeat (n) begin
      @(posedge gclk);
      for (int m = 0; m < NI; m++) model_step(m);
      @(negedge gclk);
      compare_all();
    end
  endtask

  task automatic reset_check();
    grst_n = 1'b0;
    #1;
    for (int m = 0; m < NI; m++) begin
      check($sformatf("s%0d.rst_tone_en", m), int'(ten[m]), 0);
      check($sformatf("s%0d.rst_busy", m), int'(busy[m]), 0);
    end
  endtask

  initial begin
    for (int m = 0; m < NI; m++) model_reset(m);
    start = 1'b1;
    cycle(3);
    grst_n = 1'b1;
    cycle(1);
    start = 1'b0;
    cycle(300);
    // loop pass, then let each song finish
    loop_en = 1'b1; start = 1'b1; cycle(1); start = 1'b0;
    cycle(200);
    loop_en = 1'b0;
    cycle(300);
    // stop five cycles into the first note
    start = 1'b1; cycle(1); start = 1'b0;
    cycle(6);
    stop = 1'b1; cycle(1); stop = 1'b0;
    cycle(5);
    start = 1'b1; stop = 1'b1; cycle(1); start = 1'b0; stop = 1'b0;
    cycle(3);
    // reset in the middle of a note
    start = 1'b1; cycle(1); start = 1'b0;
    cycle(5);
    reset_check();
    cycle(2);
    grst_n = 1'b1;
    cycle(2);
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 29) == 0);
      stop  = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 59) == 0) loop_en = ~loop_en;
      if (!grst_n) grst_n = 1'b1;
      else if ($urandom_range(0, 699) == 0) reset_check();
      cycle(1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
